// File: rtl/instr_encoder_loader.sv
`default_nettype none
// ============================================================================
//  Module      : instr_encoder_loader
//  Description : Encodes decoded RV32I instruction fields into 32-bit words.
//                It takes the fields from a valid/ready stream and writes the
//                words to consecutive instruction-memory addresses. It is used
//                to preload a program before the core starts. Immediates are
//                range-checked. An illegal request halts the loader and sets a
//                sticky error code.
//  Ports       : clk, reset            - clock, synchronous active-high reset
//                start                 - open a new load session
//                in_valid / in_ready   - request handshake
//                in_kind .. in_imm     - decoded instruction fields
//                imem_we/addr/wdata    - instruction-memory write port
//                count, busy, full     - session progress
//                err, err_code         - sticky error (1 kind, 2 range, 3 align)
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_kind,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic              in_f7b5,
  input  logic [31:0]       in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              full,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_FULL   = 2'd2;
  localparam logic [1:0] S_ERR    = 2'd3;

  localparam logic [3:0] K_R      = 4'd0;
  localparam logic [3:0] K_I_ALU  = 4'd1;
  localparam logic [3:0] K_LOAD   = 4'd2;
  localparam logic [3:0] K_STORE  = 4'd3;
  localparam logic [3:0] K_BRANCH = 4'd4;
  localparam logic [3:0] K_JAL    = 4'd5;
  localparam logic [3:0] K_JALR   = 4'd6;
  localparam logic [3:0] K_LUI    = 4'd7;
  localparam logic [3:0] K_AUIPC  = 4'd8;

  localparam logic [1:0] E_NONE  = 2'd0;
  localparam logic [1:0] E_KIND  = 2'd1;
  localparam logic [1:0] E_RANGE = 2'd2;
  localparam logic [1:0] E_ALIGN = 2'd3;

  localparam logic [ADDR_W:0]   c_DEPTH = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0]   c_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] c_BASE  = BASE_ADDR[ADDR_W-1:0];

  logic [1:0]         r_state;
  logic [31:0]        w_word;
  logic [1:0]         w_code;
  logic               w_accept;
  logic               w_is_shift;
  logic               w_fit_i;
  logic               w_fit_b;
  logic               w_fit_j;
  logic signed [31:0] w_imm_s;

  // in_ready depends only on registered state. It never combines with in_valid.
  assign in_ready = (r_state == S_ACTIVE) && (count < c_DEPTH);
  assign w_accept = in_valid && in_ready;
  assign busy     = (r_state == S_ACTIVE);
  assign full     = (count == c_DEPTH);

  assign w_imm_s    = $signed(in_imm);
  assign w_is_shift = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);
  assign w_fit_i    = (w_imm_s >= -32'sd2048)    && (w_imm_s <= 32'sd2047);
  assign w_fit_b    = (w_imm_s >= -32'sd4096)    && (w_imm_s <= 32'sd4094);
  assign w_fit_j    = (w_imm_s >= -32'sd1048576) && (w_imm_s <= 32'sd1048574);

  // Encoder and legality check. The range check is done first, so a
  // misalignment error is only reported for values that are in range.
  always_comb begin
    w_word = 32'd0;
    w_code = E_NONE;
    case (in_kind)
      K_R: begin
        w_word = {1'b0, in_f7b5, 5'b00000, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
      end
      K_I_ALU: begin
        if (w_is_shift) begin
          w_word = {1'b0, in_f7b5, 5'b00000, in_imm[4:0], in_rs1, in_funct3, in_rd, 7'b0010011};
          if (in_imm[31:5] != 27'd0) w_code = E_RANGE;
        end else begin
          w_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
          if (!w_fit_i) w_code = E_RANGE;
        end
      end
      K_LOAD: begin
        w_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011};
        if (!w_fit_i) w_code = E_RANGE;
      end
      K_STORE: begin
        w_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'b0100011};
        if (!w_fit_i) w_code = E_RANGE;
      end
      K_BRANCH: begin
        w_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                  in_imm[4:1], in_imm[11], 7'b1100011};
        if (!w_fit_b)        w_code = E_RANGE;
        else if (in_imm[0])  w_code = E_ALIGN;
      end
      K_JAL: begin
        w_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'b1101111};
        if (!w_fit_j)        w_code = E_RANGE;
        else if (in_imm[0])  w_code = E_ALIGN;
      end
      K_JALR: begin
        w_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b1100111};
        if (!w_fit_i) w_code = E_RANGE;
      end
      K_LUI: begin
        w_word = {in_imm[31:12], in_rd, 7'b0110111};
        if (in_imm[11:0] != 12'd0) w_code = E_ALIGN;
      end
      K_AUIPC: begin
        w_word = {in_imm[31:12], in_rd, 7'b0010111};
        if (in_imm[11:0] != 12'd0) w_code = E_ALIGN;
      end
      default: begin
        w_code = E_KIND;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      imem_we    <= 1'b0;
      imem_addr  <= c_BASE;
      imem_wdata <= 32'd0;
      count      <= '0;
      err        <= 1'b0;
      err_code   <= E_NONE;
    end else begin
      // The write strobe is a single-cycle pulse.
      imem_we <= 1'b0;
      if (start) begin
        // A request that arrives in the same cycle as start is dropped.
        r_state  <= S_ACTIVE;
        count    <= '0;
        err      <= 1'b0;
        err_code <= E_NONE;
      end else if (w_accept) begin
        if (w_code != E_NONE) begin
          r_state  <= S_ERR;
          err      <= 1'b1;
          err_code <= w_code;
        end else begin
          imem_we    <= 1'b1;
          imem_addr  <= c_BASE + count[ADDR_W-1:0];
          imem_wdata <= w_word;
          count      <= count + c_ONE;
          if (count == c_DEPTH - c_ONE) r_state <= S_FULL;
        end
      end
    end
  end

endmodule
`default_nettype wire
